// File: rtl/tx_word_gen.sv
// tx_word_gen: 16-bit PRBS7 / PRBS31 / fixed-pattern / clock-pattern test-word source for the Tx serializer.
// Single-bit error injection on dout[15] is built only when TX_WORD_GEN_ERR_INJ_EN is defined.
module tx_word_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [30:0] cfg_seed,
  input  logic [15:0] cfg_pattern,
  input  logic [15:0] cfg_len,
  input  logic        stop,
  input  logic        inj_err,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        done,
  output logic [31:0] word_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, RUN = 2'd2} state_t;

  localparam logic [1:0] MODE_PRBS7   = 2'd0;
  localparam logic [1:0] MODE_PRBS31  = 2'd1;
  localparam logic [1:0] MODE_PATTERN = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  mode_q;
  logic [30:0] seed_q;
  logic [15:0] pattern_q;
  logic [15:0] len_q;
  logic [30:0] lfsr_q, lfsr_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        done_q, done_d;
  logic        cfg_ready_q;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        accept;
  logic        burst_last;
  logic        prbs7;
  logic        inj_fire;
  logic        emit;
  logic [30:0] seed_load;
  logic [30:0] gen_s;
  logic [30:0] gen_next;
  logic        gen_bit;
  logic [15:0] gen_word;
  logic [15:0] src_word;

  assign accept     = cfg_valid & (state_q == IDLE);
  assign prbs7      = (mode_q == MODE_PRBS7);
  // word_cnt_q counts the words already presented, so equality marks the final burst word on dout now
  assign burst_last = (state_q == RUN) & (len_q != 16'h0) & (word_cnt_q == {16'h0, len_q});

`ifdef TX_WORD_GEN_ERR_INJ_EN
  logic inj_prev_q;
  always_ff @(posedge clk) begin
    if (rst) inj_prev_q <= 1'b0;
    else     inj_prev_q <= inj_err;
  end
  assign inj_fire = inj_err & ~inj_prev_q & (state_q == RUN);
`else
  logic unused_inj;
  assign unused_inj = inj_err;
  assign inj_fire   = 1'b0;
`endif

  always_comb begin
    seed_load = prbs7 ? {24'h0, seed_q[6:0]} : seed_q;
    if (seed_load == 31'h0) seed_load = prbs7 ? 31'h0000_007F : 31'h7FFF_FFFF;
  end

  // Sixteen Fibonacci steps per word; the first generated bit shifts up to dout[15]
  always_comb begin
    gen_s    = (state_q == SEED) ? seed_load : lfsr_q;
    gen_word = 16'h0;
    gen_bit  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      gen_bit  = prbs7 ? (gen_s[6] ^ gen_s[5]) : (gen_s[30] ^ gen_s[27]);
      gen_word = {gen_word[14:0], gen_bit};
      gen_s    = {gen_s[29:0], gen_bit};
    end
    gen_next = prbs7 ? {24'h0, gen_s[6:0]} : gen_s;
  end

  always_comb begin
    case (mode_q)
      MODE_PRBS7, MODE_PRBS31: src_word = gen_word;
      MODE_PATTERN:            src_word = pattern_q;
      default:                 src_word = 16'hAAAA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEED;
      SEED:    state_d = RUN;
      RUN:     if (burst_last || stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d       = 16'h0;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    word_cnt_d   = word_cnt_q;
    err_cnt_d    = err_cnt_q;
    lfsr_d       = lfsr_q;
    emit         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_cnt_d = 32'h0;
          err_cnt_d  = 8'h0;
        end
      end
      SEED: begin
        emit   = 1'b1;
        lfsr_d = mode_q[1] ? seed_load : gen_next;
      end
      RUN: begin
        if (burst_last) begin
          done_d = 1'b1;
        end else if (!stop) begin
          emit = 1'b1;
          if (!mode_q[1]) lfsr_d = gen_next;
        end
      end
      default: ;
    endcase
    if (emit) begin
      dout_d       = src_word ^ {inj_fire, 15'h0};
      dout_valid_d = 1'b1;
      if (word_cnt_q != 32'hFFFF_FFFF) word_cnt_d = word_cnt_q + 32'd1;
      if (inj_fire && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 2'd0;
      seed_q    <= 31'h0;
      pattern_q <= 16'h0;
      len_q     <= 16'h0;
    end else if (accept) begin
      mode_q    <= cfg_mode;
      seed_q    <= cfg_seed;
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= 31'h7FFF_FFFF;
      dout_q       <= 16'h0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
      word_cnt_q   <= 32'h0;
      err_cnt_q    <= 8'h0;
    end else begin
      lfsr_q       <= lfsr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      cfg_ready_q  <= (state_d == IDLE);
      word_cnt_q   <= word_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;
  assign word_cnt   = word_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tx_word_gen.sv
// Bench for tx_word_gen: a bit-serial reference model checked every cycle, directed spec scenarios,
// then randomized configuration/stop/inject/reset traffic.
module tb_tx_word_gen;
`ifdef TX_WORD_GEN_ERR_INJ_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = 2'd0;
  logic [30:0] cfg_seed = 31'h0;
  logic [15:0] cfg_pattern = 16'h0;
  logic [15:0] cfg_len = 16'h0;
  logic        stop = 1'b0;
  logic        inj_err = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        done;
  logic [31:0] word_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  tx_word_gen dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .stop(stop), .inj_err(inj_err), .dout(dout), .dout_valid(dout_valid), .done(done),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase, serial LFSR bit stream, and expected outputs
  int          m_phase = 0;      // 0 idle, 1 seeding, 2 running
  logic [1:0]  m_mode = 2'd0;
  logic [30:0] m_seed = 31'h0;
  logic [15:0] m_pat = 16'h0;
  logic [15:0] m_len = 16'h0;
  logic [30:0] m_s = 31'h7FFF_FFFF;
  logic        m_inj_prev = 1'b0;
  logic [15:0] e_dout = 16'h0;
  logic        e_valid = 1'b0;
  logic        e_done = 1'b0;
  logic        e_ready = 1'b1;
  logic [31:0] e_cnt = 32'h0;
  logic [7:0]  e_err = 8'h0;

  task automatic model_seed();
    if (m_mode == 2'd0) begin
      m_s = {24'h0, m_seed[6:0]};
      if (m_s == 31'h0) m_s = 31'h7F;
    end else begin
      m_s = m_seed;
      if (m_s == 31'h0) m_s = 31'h7FFF_FFFF;
    end
  endtask

  task automatic model_word(output logic [15:0] w);
    logic b;
    w = 16'h0;
    case (m_mode)
      2'd2: w = m_pat;
      2'd3: w = 16'hAAAA;
      default: begin
        for (int k = 0; k < 16; k++) begin
          if (m_mode == 2'd0) begin
            b = m_s[6] ^ m_s[5];
            m_s[6:0] = {m_s[5:0], b};
          end else begin
            b = m_s[30] ^ m_s[27];
            m_s = {m_s[29:0], b};
          end
          w = {w[14:0], b};
        end
      end
    endcase
  endtask

  task automatic model_emit(input logic flip);
    logic [15:0] w;
    model_word(w);
    if (flip) begin
      w[15] = ~w[15];
      if (e_err != 8'hFF) e_err = e_err + 8'd1;
    end
    e_dout = w;
    e_valid = 1'b1;
    if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
  endtask

  task automatic model_step();
    logic edge_seen;
    if (rst) begin
      m_phase = 0; e_dout = 16'h0; e_valid = 1'b0; e_done = 1'b0;
      e_cnt = 32'h0; e_err = 8'h0; m_inj_prev = 1'b0;
    end else begin
      edge_seen = INJ_EN && inj_err && !m_inj_prev;
      e_done = 1'b0;
      e_dout = 16'h0;
      e_valid = 1'b0;
      if (m_phase == 0) begin
        if (cfg_valid) begin
          m_mode = cfg_mode; m_seed = cfg_seed; m_pat = cfg_pattern; m_len = cfg_len;
          e_cnt = 32'h0; e_err = 8'h0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        model_seed();
        model_emit(1'b0);
        m_phase = 2;
      end else begin
        if (m_len != 16'h0 && e_cnt == {16'h0, m_len}) begin
          e_done = 1'b1;
          m_phase = 0;
        end else if (stop) begin
          m_phase = 0;
        end else begin
          model_emit(edge_seen);
        end
      end
      m_inj_prev = inj_err;
    end
    e_ready = (m_phase == 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_dout", 32'(dout), 32'(e_dout));
      chk("cyc_valid", 32'(dout_valid), 32'(e_valid));
      chk("cyc_done", 32'(done), 32'(e_done));
      chk("cyc_ready", 32'(cfg_ready), 32'(e_ready));
      chk("cyc_word_cnt", word_cnt, e_cnt);
      chk("cyc_err_cnt", 32'(err_cnt), 32'(e_err));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_ready", 32'(cfg_ready), 32'h1);
  endtask

  // Returns at the falling edge of cycle T+1 (accept sampled at the end of cycle T)
  task automatic do_accept(input logic [1:0] mode, input logic [30:0] seed,
                           input logic [15:0] pat, input logic [15:0] len);
    wait_idle();
    cfg_mode = mode; cfg_seed = seed; cfg_pattern = pat; cfg_len = len; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'h1);
    chk({tag, "_word_cnt"}, word_cnt, 32'h0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
  endtask

  initial begin
    bit          bits[$];
    logic [15:0] tmp;
    int          nerr, ones, nvalid, ndone;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    // PRBS7, zero seed (loads all-ones), continuous
    do_accept(2'd0, 31'h0, 16'h0, 16'h0);
    chk("s1_ready_T1", 32'(cfg_ready), 32'h0);
    @(negedge clk);
    chk("s1_first_word", 32'(dout), 32'h020C);
    chk("s1_first_valid", 32'(dout_valid), 32'h1);
    for (int k = 0; k < 40; k++) begin
      tmp = dout;
      for (int j = 0; j < 16; j++) begin
        bits.push_back(tmp[15]);
        tmp = tmp << 1;
      end
      @(negedge clk);
    end
    nerr = 0;
    ones = 0;
    for (int i = 0; i + 127 < bits.size(); i++) if (bits[i] !== bits[i + 127]) nerr++;
    for (int i = 0; i < 127; i++) if (bits[i]) ones++;
    chk("s1_prbs7_period127", 32'(nerr), 32'h0);
    chk("s1_prbs7_ones_per_period", 32'(ones), 32'd64);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s1_stopped_valid", 32'(dout_valid), 32'h0);

    // PRBS31 burst of 4
    do_accept(2'd1, 31'h7FFF_FFFF, 16'h0, 16'd4);
    nvalid = 0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      if (dout_valid) nvalid++;
      if (done) ndone++;
      if (c == 6) begin
        chk("s2_done_T6", 32'(done), 32'h1);
        chk("s2_ready_T6", 32'(cfg_ready), 32'h1);
        chk("s2_word_cnt_T6", word_cnt, 32'd4);
      end
      @(negedge clk);
    end
    chk("s2_valid_words", 32'(nvalid), 32'd4);
    chk("s2_done_pulses", 32'(ndone), 32'd1);

    // Fixed pattern, stop sampled in cycle T+10
    do_accept(2'd2, 31'($urandom), 16'hC3A5, 16'h0);
    repeat (9) @(negedge clk);
    chk("s3_dout_T10", 32'(dout), 32'h0000_C3A5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s3_valid_T11", 32'(dout_valid), 32'h0);
    chk("s3_done_T11", 32'(done), 32'h0);
    chk("s3_word_cnt_T11", word_cnt, 32'd9);

    // Error injection during RUN, then a pulse while idle
    do_accept(2'd0, 31'($urandom), 16'h0, 16'h0);
    repeat (5) @(negedge clk);
    inj_err = 1'b1;
    @(negedge clk);
    inj_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("s4_err_cnt_run", 32'(err_cnt), INJ_EN ? 32'd1 : 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    do_accept(2'd3, 31'h0, 16'h0, 16'd2);
    wait_idle();
    inj_err = 1'b1;
    @(negedge clk);
    inj_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4_err_cnt_idle", 32'(err_cnt), 32'h0);

    // Reset mid-burst, then restart
    do_accept(2'd3, 31'h0, 16'h0, 16'd100);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("s5_midburst_rst");
    do_accept(2'd3, 31'h0, 16'h0, 16'd5);
    chk("s5_restart_cnt", word_cnt, 32'h0);

    // Stop coincident with the last word of a 3-word burst; cfg_valid held through RUN
    do_accept(2'd0, 31'($urandom), 16'h0, 16'd3);
    cfg_valid = 1'b1;
    cfg_mode = 2'd3;
    cfg_len = 16'd2;
    @(negedge clk);
    @(negedge clk);
    chk("s6_ready_T3", 32'(cfg_ready), 32'h0);
    chk("s6_valid_T3", 32'(dout_valid), 32'h1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s6_done_T5", 32'(done), 32'h1);
    chk("s6_ready_T5", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("s6_reaccept_T6", 32'(cfg_ready), 32'h0);
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       cfg_seed = 31'h0;
        1:       cfg_seed = {24'($urandom), 7'h0};
        default: cfg_seed = 31'($urandom);
      endcase
      cfg_pattern = 16'($urandom);
      cfg_len = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 40));
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) inj_err = ~inj_err;
      @(negedge clk);
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    stop = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
